// File: rtl/fpaddsub_exec_pipe.sv
// Mantissa add/subtract execution stage: resolves the effective operation,
// forms the raw magnitude, sign and flags, and carries them through an elastic pipeline.
module fpaddsub_exec_pipe #(
  parameter int MANT_W  = 23,
  parameter int GUARD_W = 5,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4,
  localparam int W      = MANT_W + 1 + GUARD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mmax,
  input  logic [W-1:0]      mmin,
  input  logic              sa,
  input  logic              sb,
  input  logic              max_ab,
  input  logic              op_mode,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W:0]        sum,
  output logic              psgn,
  output logic              opr,
  output logic              zero,
  output logic              borrow,
  output logic [TAG_W-1:0]  tag_out,
  output logic [2:0]        occupancy
);

  localparam int PW = W + 1 + 4 + TAG_W;

  logic [W:0]        w_a, w_b, w_add, w_dif, w_ndif, w_sum;
  logic              w_opr, w_base, w_bgt, w_psgn, w_zero, w_borrow, w_xfer;
  logic [PW-1:0]     w_pl0;
  logic [STAGES-1:0] r_v, w_adv, w_load, w_in_v;
  logic [PW-1:0]     r_pl  [STAGES];
  logic [PW-1:0]     w_src [STAGES];
  logic              r_live;
  logic [2:0]        w_occ;

  assign w_a    = {1'b0, 1'b1, mmax, {GUARD_W{1'b0}}};
  assign w_b    = {1'b0, mmin};
  assign w_add  = w_a + w_b;
  assign w_dif  = w_a - w_b;
  assign w_ndif = w_b - w_a;
  assign w_bgt  = (w_b > w_a);
  assign w_opr  = op_mode ^ sa ^ sb;
  assign w_base = max_ab ? sb : sa;

  // Result magnitude, sign and flags; a borrow is corrected by swapping the operands.
  always_comb begin
    w_sum    = w_add;
    w_psgn   = w_base;
    w_zero   = 1'b0;
    w_borrow = 1'b0;
    if (w_opr) begin
      if (w_bgt) begin
        w_sum    = w_ndif;
        w_psgn   = ~w_base;
        w_borrow = 1'b1;
      end else begin
        w_sum    = w_dif;
        w_psgn   = w_base;
        w_borrow = 1'b0;
      end
      if (w_sum == {(W+1){1'b0}}) begin
        w_zero = 1'b1;
        w_psgn = 1'b0;
      end else begin
        w_zero = 1'b0;
      end
    end else begin
      w_sum    = w_add;
      w_psgn   = w_base;
      w_zero   = 1'b0;
      w_borrow = 1'b0;
    end
  end

  assign w_pl0 = {w_sum, w_psgn, w_opr, w_zero, w_borrow, tag_in};

  // Advance chain: ready ripples combinationally from the output back to stage 1.
  always_comb begin
    w_adv = {STAGES{1'b0}};
    w_adv[STAGES-1] = r_v[STAGES-1] & out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_adv[i] = r_v[i] & (~r_v[i+1] | w_adv[i+1]);
    end
  end

  assign w_load   = ~r_v | w_adv;
  assign in_ready = r_live & w_load[0];
  assign w_xfer   = in_valid & in_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_first
      assign w_src[g]  = w_pl0;
      assign w_in_v[g] = w_xfer;
    end else begin : g_next
      assign w_src[g]  = r_pl[g-1];
      assign w_in_v[g] = w_adv[g-1];
    end
  end

  // Stage valid bits and payload; flush wins over load, payload only moves with valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_v    <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        r_pl[i] <= {PW{1'b0}};
      end
    end else begin
      r_live <= 1'b1;
      for (int i = 0; i < STAGES; i++) begin
        if (flush) begin
          r_v[i] <= 1'b0;
        end else if (w_load[i]) begin
          r_v[i] <= w_in_v[i];
        end else begin
          r_v[i] <= r_v[i];
        end
        if (!flush && w_load[i] && w_in_v[i]) begin
          r_pl[i] <= w_src[i];
        end else begin
          r_pl[i] <= r_pl[i];
        end
      end
    end
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    w_occ = 3'd0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ = w_occ + {2'b00, r_v[i]};
    end
  end

  assign occupancy = w_occ;
  assign out_valid = r_v[STAGES-1];
  assign {sum, psgn, opr, zero, borrow, tag_out} = r_pl[STAGES-1];

endmodule

// File: tb/tb_fpaddsub_exec_pipe.sv
// Self-checking bench for fpaddsub_exec_pipe: directed vector table, back-pressure,
// flush and async-reset sequences, and randomized traffic against a queue-based model.
module tb_fpaddsub_exec_pipe;
  localparam int MANT_W = 23, GUARD_W = 5, STAGES = 2, TAG_W = 4;
  localparam int W = MANT_W + 1 + GUARD_W;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [MANT_W-1:0] mmax;
  logic [W-1:0] mmin;
  logic sa, sb, max_ab, op_mode, psgn, opr, zero, borrow;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic [W:0] sum;
  logic [2:0] occupancy;

  always #5 clk = ~clk;

  fpaddsub_exec_pipe #(.MANT_W(MANT_W), .GUARD_W(GUARD_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mmax(mmax), .mmin(mmin), .sa(sa), .sb(sb), .max_ab(max_ab), .op_mode(op_mode),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .psgn(psgn), .opr(opr), .zero(zero), .borrow(borrow), .tag_out(tag_out),
    .occupancy(occupancy));

  typedef struct packed {
    logic [W:0] sum;
    logic psgn, opr, zero, borrow;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct {
    logic [MANT_W-1:0] mmax;
    logic [W-1:0] mmin;
    logic sa, sb, max_ab, op_mode;
    logic [W:0] e_sum;
    logic e_psgn, e_opr, e_zero, e_borrow;
  } vec_t;

  vec_t vecs[7];
  res_t q[$];
  logic [TAG_W-1:0] seen[$];
  int errors, checks, peak;
  logic last_xin;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned integer arithmetic on the full magnitudes.
  function automatic res_t ref_model(input logic [MANT_W-1:0] mx, input logic [W-1:0] mn,
                                     input logic as_, input logic bs_, input logic mab,
                                     input logic op, input logic [TAG_W-1:0] t);
    logic [31:0] a, b, s;
    logic eff, base;
    res_t r;
    a = 32'h1000_0000 + 32'(mx) * 32'd32;
    b = 32'(mn);
    eff = op ^ as_ ^ bs_;
    base = mab ? bs_ : as_;
    r.psgn = base;
    r.borrow = 1'b0;
    r.zero = 1'b0;
    if (!eff) s = a + b;
    else if (b > a) begin
      s = b - a;
      r.psgn = ~base;
      r.borrow = 1'b1;
    end else s = a - b;
    if (eff && s == 32'd0) begin
      r.zero = 1'b1;
      r.psgn = 1'b0;
    end
    r.sum = s[W:0];
    r.opr = eff;
    r.tag = t;
    return r;
  endfunction

  task automatic rand_ops();
    mmax = MANT_W'($urandom);
    case ($urandom_range(0, 2))
      0: mmin = W'($urandom);
      1: mmin = {1'b1, mmax, 5'b00000} + W'($urandom_range(0, 64)) - W'(32);
      default: mmin = W'($urandom) >> $urandom_range(0, 28);
    endcase
    sa = 1'($urandom);
    sb = 1'($urandom);
    max_ab = 1'($urandom);
    op_mode = 1'($urandom);
  endtask

  // One cycle: entered just after a negedge with inputs already driven.
  task automatic step();
    res_t got, pend;
    logic xin, xout;
    #1;
    got = {sum, psgn, opr, zero, borrow, tag_out};
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'((q.size() < STAGES) || out_ready));
    if (occupancy > peak) peak = occupancy;
    if (out_valid) begin
      if (q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else check("result", 64'(got), 64'(q[0]));
    end
    xin = in_valid & in_ready;
    xout = out_valid & out_ready;
    last_xin = xin;
    pend = ref_model(mmax, mmin, sa, sb, max_ab, op_mode, tag_in);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (xout && q.size() > 0) begin
        seen.push_back(q[0].tag);
        void'(q.pop_front());
      end
      if (xin) q.push_back(pend);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic got_ov;
    int next_tag;
    res_t exp_r;

    vecs[0] = '{23'h0,      29'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 30'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{23'h0,      29'h1000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 30'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{23'h0,      29'h1800_0000, 1'b0, 1'b1, 1'b0, 1'b0, 30'h0800_0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{23'h7FFFFF, 29'h1FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 30'h3FFF_FFDF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{23'h400000, 29'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 30'h17FF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{23'h0,      29'h1FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{23'h123456, 29'h1246_8AC0, 1'b1, 1'b1, 1'b1, 1'b1, 30'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};

    errors = 0; checks = 0; peak = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mmax = '0; mmin = '0; sa = 1'b0; sb = 1'b0; max_ab = 1'b0; op_mode = 1'b0; tag_in = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_payload", 64'({sum, psgn, opr, zero, borrow, tag_out}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 check("rel_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one at a time, with latency measured in edges.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mmax = vecs[i].mmax; mmin = vecs[i].mmin; sa = vecs[i].sa; sb = vecs[i].sb;
      max_ab = vecs[i].max_ab; op_mode = vecs[i].op_mode; tag_in = TAG_W'(i);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; got_ov = 1'b0;
      for (int c = 0; c < 8 && !got_ov; c++) begin
        lat++;
        @(negedge clk);
        #1;
        if (out_valid) got_ov = 1'b1;
        else @(posedge clk);
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
      exp_r = {vecs[i].e_sum, vecs[i].e_psgn, vecs[i].e_opr, vecs[i].e_zero, vecs[i].e_borrow, TAG_W'(i)};
      check($sformatf("vec%0d_result", i), 64'({sum, psgn, opr, zero, borrow, tag_out}), 64'(exp_r));
      @(posedge clk);
    end
    @(negedge clk);

    // Back-pressure: six tagged ops with out_ready low for four cycles.
    next_tag = 0; peak = 0; seen.delete();
    for (int cyc = 0; cyc < 40 && !(next_tag == 6 && q.size() == 0); cyc++) begin
      in_valid = (next_tag < 6);
      tag_in = TAG_W'(next_tag);
      rand_ops();
      out_ready = !(cyc >= 2 && cyc < 6);
      step();
      if (last_xin) next_tag++;
    end
    check("bp_drained", 64'(next_tag == 6 && q.size() == 0), 64'd1);
    check("bp_peak", 64'(peak), 64'd2);
    check("bp_count", 64'(seen.size()), 64'd6);
    for (int k = 0; k < 6 && k < seen.size(); k++) check("bp_order", 64'(seen[k]), 64'(k));

    // Flush with a full pipeline and a simultaneous input.
    in_valid = 1'b1; out_ready = 1'b0;
    tag_in = 4'd1; rand_ops(); step();
    tag_in = 4'd2; rand_ops(); step();
    flush = 1'b1; tag_in = 4'd3; rand_ops(); step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_occupancy", 64'(occupancy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    step();
    seen.delete();
    in_valid = 1'b1; out_ready = 1'b1; tag_in = 4'd9; rand_ops(); step();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) step();
    check("flush_after_op", 64'(seen.size() == 1 && seen[0] == 4'd9), 64'd1);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tag_in = TAG_W'($urandom);
      rand_ops();
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) step();
    check("rand_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset between edges with a full pipeline.
    in_valid = 1'b1; out_ready = 1'b0;
    rand_ops(); step();
    rand_ops(); step();
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd0);
    check("ar_occupancy", 64'(occupancy), 64'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 check("ar_rel_in_ready", 64'(in_ready), 64'd1);
    mmax = vecs[0].mmax; mmin = vecs[0].mmin; sa = vecs[0].sa; sb = vecs[0].sb;
    max_ab = vecs[0].max_ab; op_mode = vecs[0].op_mode; tag_in = 4'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    #1 check("ar_lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 check("ar_lat_valid", 64'(out_valid), 64'd1);
    check("ar_result", 64'({sum, tag_out}), 64'({30'h2000_0000, 4'd3}));
    @(negedge clk);
    #1 check("ar_empty", 64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
